// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sequencer sharing one byte-level SPI master
// between NUM_REQ requesters, with burst locking and a hold timeout.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   req, req_data,        per-requester byte request (level), tx byte
//   req_last                (requester i at [8i+7:8i]) and last-of-burst flag
//   ack, rsp_valid        one-hot 1-cycle pulses to the owner
//   rsp_data              received byte, valid with rsp_valid
//   grant                 one-hot current owner, 0 when idle
//   abort                 1-cycle pulse when a burst times out in HOLD
//   m_start, m_tx_data    start pulse and tx byte to the SPI master
//   m_busy, m_done,       SPI master status and rx byte (valid with m_done)
//   m_rx_data
module spi_req_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 abort,
  output logic                 m_start,
  output logic [7:0]           m_tx_data,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rx_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_TIMEOUT);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                     state;
  logic [IW-1:0]              owner;
  logic [IW-1:0]              last_owner;
  logic                       last_q;
  logic [CW-1:0]              hold_cnt;

  logic [NUM_REQ-1:0][7:0]    req_bytes;
  logic                       sel_found;
  logic [IW-1:0]              sel_idx;
  logic [IW-1:0]              cand_idx;

  assign req_bytes = req_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Rotating priority: the search starts one past the previous owner and
  // wraps, so the previous owner is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IW'((32'(last_owner) + k) % NUM_REQ);
      if (!sel_found && req[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // m_tx_data doubles as the latched byte: it is loaded when the byte is
  // accepted and only changes again at the next accept, which can only
  // happen after m_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_INIT;
      last_q     <= 1'b0;
      hold_cnt   <= '0;
      ack        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      grant      <= '0;
      abort      <= 1'b0;
      m_start    <= 1'b0;
      m_tx_data  <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      abort     <= 1'b0;
      m_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            owner     <= sel_idx;
            grant     <= onehot(sel_idx);
            ack       <= onehot(sel_idx);
            m_tx_data <= req_bytes[sel_idx];
            last_q    <= req_last[sel_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy) begin
            m_start <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (m_done) begin
            rsp_valid <= onehot(owner);
            rsp_data  <= m_rx_data;
            if (last_q) begin
              grant      <= '0;
              last_owner <= owner;
              state      <= IDLE;
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (req[owner]) begin
            ack       <= onehot(owner);
            m_tx_data <= req_bytes[owner];
            last_q    <= req_last[owner];
            state     <= ISSUE;
          end else if (hold_cnt == HOLD_LAST) begin
            abort      <= 1'b1;
            grant      <= '0;
            last_owner <= owner;
            state      <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: self-checking bench for spi_req_arbiter (NUM_REQ=3,
// HOLD_TIMEOUT=16). A behavioural SPI master answers each m_start after a
// few busy cycles with rx = tx ^ 8'h99; a monitor pops expected tx bytes
// and responses from scoreboard queues as the DUT produces them.
module tb_spi_req_arbiter;

  localparam int N  = 3;
  localparam int HT = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_data;
  logic [N-1:0]   grant;
  logic           abort;
  logic           m_start;
  logic [7:0]     m_tx_data;
  logic           m_busy;
  logic           m_done;
  logic [7:0]     m_rx_data;

  logic model_busy, force_busy, model_done, stray_done;
  assign m_busy = model_busy | force_busy;
  assign m_done = model_done | stray_done;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .ack(ack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .grant(grant), .abort(abort), .m_start(m_start),
    .m_tx_data(m_tx_data), .m_busy(m_busy), .m_done(m_done),
    .m_rx_data(m_rx_data)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    int             exp_idx;
  } vec_t;

  sb_t exp_tx[$];
  sb_t exp_rsp[$];

  int n_checks = 0;
  int n_err    = 0;
  int start_count = 0;
  int abort_count = 0;

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sb(input int idx, input logic [7:0] data, input bit with_rsp);
    sb_t e;
    e.idx  = idx;
    e.data = data;
    exp_tx.push_back(e);
    if (with_rsp) begin
      e.data = data ^ 8'h99;
      exp_rsp.push_back(e);
    end
  endtask

  task automatic wait_ack(input int idx, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack != '0) break;
    end
    chk(name, 32'(ack), 32'(oh(idx)));
    chk({name, " grant"}, 32'(grant), 32'(oh(idx)));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && exp_tx.size() == 0 && grant == '0) break;
    end
    chk({name, " drained"}, 32'(exp_rsp.size() + exp_tx.size()), 0);
    chk({name, " grant idle"}, 32'(grant), 0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    req   = '0;
    exp_tx.delete();
    exp_rsp.delete();
    @(negedge clk);
    chk(name, 32'({ack, rsp_valid, grant, abort, m_start, rsp_data, m_tx_data}), 0);
    rst_n = 1'b1;
  endtask

  // Behavioural SPI master: busy for 3 cycles after m_start, then m_done.
  initial begin : master
    logic [7:0] tx_l;
    int cnt;
    model_busy = 1'b0;
    model_done = 1'b0;
    m_rx_data  = '0;
    tx_l = '0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (m_start === 1'b1) begin
        tx_l       = m_tx_data;
        cnt        = 3;
        model_busy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          model_busy = 1'b0;
          m_rx_data  = tx_l ^ 8'h99;
        end
      end
    end
  end

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        start_count++;
        chk("m_start expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          chk("m_tx_data", 32'(m_tx_data), 32'(e.data));
          chk("grant at m_start", 32'(grant), 32'(oh(e.idx)));
        end
      end
      if (|rsp_valid) begin
        chk("rsp_valid expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          chk("rsp_valid owner", 32'(rsp_valid), 32'(oh(e.idx)));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
      if (abort === 1'b1) abort_count++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[11];
    logic [8*N-1:0] d;
    int s0, a0, c_rsp, c_ab;
    bit ack_seen;

    vecs[0]  = '{3'b111, 24'h33_22_11, 0};
    vecs[1]  = '{3'b111, 24'h36_25_14, 1};
    vecs[2]  = '{3'b111, 24'h39_28_17, 2};
    vecs[3]  = '{3'b111, 24'h3C_2B_1A, 0};
    vecs[4]  = '{3'b110, 24'h4F_4E_4D, 1};
    vecs[5]  = '{3'b011, 24'h52_51_50, 0};
    vecs[6]  = '{3'b100, 24'h63_62_61, 2};
    vecs[7]  = '{3'b101, 24'h74_73_72, 0};
    vecs[8]  = '{3'b001, 24'h85_84_83, 0};
    vecs[9]  = '{3'b010, 24'h96_95_94, 1};
    vecs[10] = '{3'b001, 24'hA7_A6_A5, 0};

    rst_n = 1'b0;
    req = '0; req_data = '0; req_last = '0;
    force_busy = 1'b0; stray_done = 1'b0;
    @(negedge clk);
    do_reset("reset outputs");

    // Single byte from requester 0.
    req = 3'b001; req_data = 24'h00_00_A5; req_last = 3'b001;
    s0 = start_count;
    wait_ack(0, "single ack");
    push_sb(0, 8'hA5, 1);
    req = '0;
    @(negedge clk);
    chk("ack is one pulse", 32'(ack), 0);
    wait_idle("single");
    chk("single one m_start", 32'(start_count - s0), 1);

    // Table-driven round robin of single-byte transfers.
    do_reset("reset before table");
    for (int v = 0; v < 11; v++) begin
      req = vecs[v].req; req_data = vecs[v].data; req_last = 3'b111;
      wait_ack(vecs[v].exp_idx, $sformatf("table[%0d] ack", v));
      d = vecs[v].data;
      push_sb(vecs[v].exp_idx, d[8*vecs[v].exp_idx +: 8], 1);
      req = '0;
      wait_idle($sformatf("table[%0d]", v));
    end

    // Burst lock: requester 1 keeps the grant for 3 bytes while 0 and 2 wait.
    req = 3'b111; req_data = 24'hC2_11_C0; req_last = 3'b101;
    wait_ack(1, "burst byte0 ack");
    push_sb(1, 8'h11, 1);
    req_data[15:8] = 8'h22;
    wait_ack(1, "burst byte1 ack");
    push_sb(1, 8'h22, 1);
    req_data[15:8] = 8'h33; req_last[1] = 1'b1;
    wait_ack(1, "burst byte2 ack");
    push_sb(1, 8'h33, 1);
    req[1] = 1'b0;
    wait_ack(2, "after burst ack");
    push_sb(2, 8'hC2, 1);
    req[2] = 1'b0;
    wait_ack(0, "after burst ack r0");
    push_sb(0, 8'hC0, 1);
    req = '0;
    wait_idle("burst");

    // Hold timeout: requester 0 leaves a burst open and goes quiet.
    a0 = abort_count;
    req = 3'b001; req_data = 24'h00_00_55; req_last = 3'b000;
    wait_ack(0, "hold ack");
    push_sb(0, 8'h55, 1);
    req = 3'b100; req_data = 24'h77_00_55; req_last = 3'b100;
    c_rsp = -100; c_ab = -1; ack_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (|rsp_valid) c_rsp = c;
      if (|ack) ack_seen = 1'b1;
      if (abort === 1'b1) begin
        c_ab = c;
        chk("grant at abort", 32'(grant), 0);
        break;
      end
    end
    chk("hold timeout cycles", 32'(c_ab - c_rsp), HT);
    chk("no ack during hold", 32'(ack_seen), 0);
    wait_ack(2, "after abort ack");
    push_sb(2, 8'h77, 1);
    req = '0;
    wait_idle("hold");
    chk("abort pulses", 32'(abort_count - a0), 1);

    // Busy back-pressure on the issue of a single byte.
    force_busy = 1'b1;
    req = 3'b001; req_data = 24'h00_00_9E; req_last = 3'b001;
    wait_ack(0, "busy ack");
    push_sb(0, 8'h9E, 1);
    req = '0;
    s0 = start_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("m_start held off %0d", i), 32'(m_start), 0);
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("m_start after busy", 32'(m_start), 1);
    wait_idle("busy");
    chk("busy one m_start", 32'(start_count - s0), 1);

    // Stray m_done while idle must not produce a response.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray done no rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("stray done no rsp 2", 32'(rsp_valid), 0);

    // Reset while the first byte of a 2-byte burst is in flight.
    req = 3'b010; req_data = 24'h00_D1_00; req_last = 3'b000;
    wait_ack(1, "reset-burst ack");
    push_sb(1, 8'hD1, 0);
    req = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_start === 1'b1) break;
    end
    chk("m_start before reset", 32'(m_start), 1);
    do_reset("reset mid-op outputs");
    req = 3'b111; req_data = 24'hE2_E1_E0; req_last = 3'b111;
    wait_ack(0, "post-reset ack");
    push_sb(0, 8'hE0, 1);
    req = '0;
    wait_idle("post-reset");

    chk("total aborts", 32'(abort_count), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
